// File: rtl/axi4_slave_mem_if.sv
// AXI4 (full) bus bundle shared by the slave memory and its masters.
// The master drives requests and write data; the slave drives ready, response and read data.
interface axi4_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int USER_W = 1
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic [3:0]        awregion;
  logic [USER_W-1:0] awuser;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic [USER_W-1:0] wuser;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic [USER_W-1:0] buser;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic [3:0]        arregion;
  logic [USER_W-1:0] aruser;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [USER_W-1:0] ruser;
  logic              rvalid;
  logic              rready;

  modport master_mp (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave_mp (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed memory; independent write (AW/W/B) and read (AR/R)
// engines, one outstanding burst each, FIXED/INCR/WRAP addressing with SLVERR on bad requests.
module axi4_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int USER_W    = 1,
  parameter int MEM_DEPTH = 1024
) (
  input  logic     aclk,
  input  logic     areset_n,
  axi4_if.slave_mp axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic bad_burst(input logic [7:0] len, input logic [1:0] burst);
    return (burst == 2'b11) ||
           ((burst == BURST_WRAP) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic bad_size(input logic [2:0] size);
    return (32'd1 << size) > 32'(STRB_W);
  endfunction

  // Bad bursts are stored as INCR, so this only ever sees legal WRAP lengths.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] one;
    logic [ADDR_W-1:0] bytes;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] result;
    one   = ADDR_W'(1);
    bytes = one << size;
    case (len)
      8'd1:    mask = (bytes << 1) - one;
      8'd3:    mask = (bytes << 2) - one;
      8'd7:    mask = (bytes << 3) - one;
      8'd15:   mask = (bytes << 4) - one;
      default: mask = bytes - one;
    endcase
    case (burst)
      BURST_FIXED: result = addr;
      BURST_WRAP:  result = (addr & ~mask) | ((addr + bytes) & mask);
      default:     result = (addr & ~(bytes - one)) + bytes;
    endcase
    return result;
  endfunction

  w_state_t          w_state, w_next;
  logic              awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0]   bid_q, w_id;
  logic [1:0]        bresp_q, w_burst;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic              w_err, w_noacc;
  logic              aw_hs, w_hs, b_hs, w_last_beat, w_oob, w_beat_err;
  logic [IDX_W-1:0]  w_idx;

  assign aw_hs       = (w_state == W_IDLE) && awready_q && axi.awvalid;
  assign w_hs        = (w_state == W_DATA) && wready_q && axi.wvalid;
  assign b_hs        = (w_state == W_RESP) && bvalid_q && axi.bready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_oob       = (w_addr >> OFF_W) >= ADDR_W'(MEM_DEPTH);
  assign w_beat_err  = (axi.wlast != w_last_beat) || w_oob;
  assign w_idx       = w_addr[OFF_W +: IDX_W];

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
      w_noacc   <= 1'b0;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_next == W_IDLE);
      wready_q  <= (w_next == W_DATA);
      bvalid_q  <= (w_next == W_RESP);
      if (aw_hs) begin
        w_id    <= axi.awid;
        w_addr  <= axi.awaddr;
        w_len   <= axi.awlen;
        w_size  <= axi.awsize;
        w_burst <= bad_burst(axi.awlen, axi.awburst) ? BURST_INCR : axi.awburst;
        w_cnt   <= '0;
        w_err   <= bad_burst(axi.awlen, axi.awburst) || bad_size(axi.awsize);
        w_noacc <= bad_size(axi.awsize);
      end else if (w_hs) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        if (w_beat_err) w_err <= 1'b1;
      end
      if (w_hs && w_last_beat) begin
        bid_q   <= w_id;
        bresp_q <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // No reset here: memory contents survive reset, but a beat in the reset cycle is dropped.
  always_ff @(posedge aclk) begin
    if (areset_n && w_hs && !w_noacc && !w_oob) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (axi.wstrb[i]) mem[w_idx][i*8 +: 8] <= axi.wdata[i*8 +: 8];
      end
    end
  end

  r_state_t          r_state, r_next;
  logic              arready_q, rvalid_q, rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q, r_src_data;
  logic [1:0]        rresp_q, r_burst;
  logic [ADDR_W-1:0] r_addr, r_src_addr;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic              r_err, r_noacc, r_src_err, r_src_noacc, r_src_oob;
  logic              ar_hs, r_hs, r_last_beat, r_load;
  logic [IDX_W-1:0]  r_src_idx;

  assign ar_hs       = (r_state == R_IDLE) && arready_q && axi.arvalid;
  assign r_hs        = (r_state == R_DATA) && rvalid_q && axi.rready;
  assign r_last_beat = (r_cnt == r_len);
  assign r_load      = ar_hs || (r_hs && !r_last_beat);

  // Address of the beat about to be presented: the AR address on accept, else the successor.
  assign r_src_addr  = ar_hs ? axi.araddr : next_addr(r_addr, r_len, r_size, r_burst);
  assign r_src_err   = ar_hs ? (bad_burst(axi.arlen, axi.arburst) || bad_size(axi.arsize)) : r_err;
  assign r_src_noacc = ar_hs ? bad_size(axi.arsize) : r_noacc;
  assign r_src_oob   = (r_src_addr >> OFF_W) >= ADDR_W'(MEM_DEPTH);
  assign r_src_idx   = r_src_addr[OFF_W +: IDX_W];
  assign r_src_data  = (r_src_noacc || r_src_oob) ? '0 : mem[r_src_idx];

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_noacc   <= 1'b0;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      rvalid_q  <= (r_next == R_DATA);
      if (ar_hs) begin
        rid_q   <= axi.arid;
        r_len   <= axi.arlen;
        r_size  <= axi.arsize;
        r_burst <= bad_burst(axi.arlen, axi.arburst) ? BURST_INCR : axi.arburst;
        r_err   <= r_src_err;
        r_noacc <= r_src_noacc;
        r_cnt   <= '0;
        rlast_q <= (axi.arlen == 8'd0);
      end else if (r_hs && !r_last_beat) begin
        r_cnt   <= r_cnt + 8'd1;
        rlast_q <= ((r_cnt + 8'd1) == r_len);
      end
      if (r_load) begin
        r_addr  <= r_src_addr;
        rdata_q <= r_src_data;
        rresp_q <= (r_src_err || r_src_oob) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.buser   = '0;
  assign axi.bvalid  = bvalid_q;
  assign axi.arready = arready_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;
  assign axi.ruser   = '0;
  assign axi.rvalid  = rvalid_q;

  logic unused_sideband;
  assign unused_sideband = ^{axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion, axi.awuser,
                             axi.wuser, axi.arlock, axi.arcache, axi.arprot, axi.arqos, axi.arregion,
                             axi.aruser};
endmodule
